// File: rtl/nn_image_driver_pkg.sv
// Shared constants and FSM encoding for the NN image driver.
// Defaults describe one 28x28 binary image and a 4-bit digit prediction.
package nn_image_driver_pkg;
    localparam int NUM_PIXELS_DEF   = 784;
    localparam int IDX_W_DEF        = 10;
    localparam int PRED_TIMEOUT_DEF = 4096;
    localparam int TO_W_DEF         = 13;
    localparam int DIGIT_W          = 4;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RDY,
        STREAM,
        WAIT_PRED,
        ACK
    } state_t;
endpackage

// File: rtl/nn_image_driver_if.sv
// Handshake between the image driver (master) and the neural-network controller (slave).
interface nn_image_driver_if;
    import nn_image_driver_pkg::*;

    logic               readyForInputs;
    logic               inputsInbound;
    logic               inputPixel;
    logic               predictionReady;
    logic [DIGIT_W-1:0] predictionOut;
    logic               predictionRecieved;

    modport master (
        input  readyForInputs, predictionReady, predictionOut,
        output inputsInbound, inputPixel, predictionRecieved
    );

    modport slave (
        output readyForInputs, predictionReady, predictionOut,
        input  inputsInbound, inputPixel, predictionRecieved
    );
endinterface

// File: rtl/nn_image_driver_buffer.sv
// One-bit-per-pixel image register file: one write port, one asynchronous read
// port with write-first bypass. Contents survive reset.
module nn_image_driver_buffer
    import nn_image_driver_pkg::*;
#(
    parameter int NUM_PIXELS = NUM_PIXELS_DEF,
    parameter int IDX_W      = IDX_W_DEF
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic             wr_data,
    input  logic [IDX_W-1:0] rd_addr,
    output logic             rd_data
);
    logic [NUM_PIXELS-1:0] mem;
    logic                  wr_ok;

    // Out-of-range addresses are dropped rather than aliased.
    assign wr_ok = wr_en && ({1'b0, wr_addr} < (IDX_W+1)'(NUM_PIXELS));

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_addr] <= wr_data;
    end

    assign rd_data = (wr_ok && wr_addr == rd_addr) ? wr_data : mem[rd_addr];
endmodule

// File: rtl/nn_image_driver.sv
// Streams a buffered binary image into the NN controller on start, then collects
// the prediction (or flags a timeout) and reports it to the host.
module nn_image_driver
    import nn_image_driver_pkg::*;
#(
    parameter int NUM_PIXELS   = NUM_PIXELS_DEF,
    parameter int IDX_W        = IDX_W_DEF,
    parameter int PRED_TIMEOUT = PRED_TIMEOUT_DEF,
    parameter int TO_W         = TO_W_DEF
) (
    input  logic               masterClk,
    input  logic               reset,
    input  logic               img_wr_en,
    input  logic [IDX_W-1:0]   img_wr_addr,
    input  logic               img_wr_data,
    input  logic               start,
    output logic               busy,
    output logic               result_valid,
    output logic [DIGIT_W-1:0] result_digit,
    output logic               err_timeout,
    nn_image_driver_if.master  net
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PIXELS - 1);
    // Deciding at PRED_TIMEOUT-2 lands the registered pulse PRED_TIMEOUT cycles after the last pixel.
    localparam logic [TO_W-1:0]  TO_FIRE  = TO_W'(PRED_TIMEOUT - 2);

    state_t             state, state_n;
    logic [IDX_W-1:0]   idx, idx_n, rd_addr;
    logic [TO_W-1:0]    cnt, cnt_n;
    logic               rd_data;
    logic               busy_n, valid_n, err_n, inbound_n, pixel_n, recv_n;
    logic [DIGIT_W-1:0] digit_n;

    // Fetch the pixel that will be presented next cycle.
    assign rd_addr = (state == STREAM && idx != LAST_IDX) ? idx + 1'b1 : '0;

    nn_image_driver_buffer #(.NUM_PIXELS(NUM_PIXELS), .IDX_W(IDX_W)) u_buf (
        .clk     (masterClk),
        .wr_en   (img_wr_en),
        .wr_addr (img_wr_addr),
        .wr_data (img_wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge masterClk or posedge reset) begin
        if (reset) begin
            state                  <= IDLE;
            idx                    <= '0;
            cnt                    <= '0;
            busy                   <= 1'b0;
            result_valid           <= 1'b0;
            result_digit           <= '0;
            err_timeout            <= 1'b0;
            net.inputsInbound      <= 1'b0;
            net.inputPixel         <= 1'b0;
            net.predictionRecieved <= 1'b0;
        end else begin
            state                  <= state_n;
            idx                    <= idx_n;
            cnt                    <= cnt_n;
            busy                   <= busy_n;
            result_valid           <= valid_n;
            result_digit           <= digit_n;
            err_timeout            <= err_n;
            net.inputsInbound      <= inbound_n;
            net.inputPixel         <= pixel_n;
            net.predictionRecieved <= recv_n;
        end
    end

    always_comb begin
        state_n   = state;
        idx_n     = idx;
        cnt_n     = cnt;
        busy_n    = busy;
        valid_n   = 1'b0;
        err_n     = 1'b0;
        digit_n   = result_digit;
        inbound_n = 1'b0;
        pixel_n   = 1'b0;
        recv_n    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = WAIT_RDY;
                    busy_n  = 1'b1;
                end
            end
            WAIT_RDY: begin
                if (net.readyForInputs) begin
                    state_n   = STREAM;
                    idx_n     = '0;
                    inbound_n = 1'b1;
                    pixel_n   = rd_data;
                end
            end
            STREAM: begin
                if (idx == LAST_IDX) begin
                    state_n = WAIT_PRED;
                    cnt_n   = '0;
                end else begin
                    idx_n     = idx + 1'b1;
                    inbound_n = 1'b1;
                    pixel_n   = rd_data;
                end
            end
            WAIT_PRED: begin
                if (net.predictionReady) begin
                    state_n = ACK;
                    digit_n = net.predictionOut;
                    recv_n  = 1'b1;
                end else if (cnt == TO_FIRE) begin
                    state_n = IDLE;
                    err_n   = 1'b1;
                    busy_n  = 1'b0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ACK: begin
                if (!net.predictionReady) begin
                    state_n = IDLE;
                    valid_n = 1'b1;
                    busy_n  = 1'b0;
                end else begin
                    recv_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule
